// File: rtl/fb_mem_arbiter.sv
// Two-requester frame-buffer memory arbiter: turns writer/reader req/ack handshakes into
// mutually exclusive active-low memory strobes, with bounded reads. Macro: FB_ARB_WR_PRIORITY_EN.
`default_nettype none

module fb_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29,
    parameter int WR_CYCLES  = 2,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    output logic                  wr_ack,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [DATA_WIDTH-1:0] rd_data,

    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid
);

    localparam int CNT_MAX = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic             WR_ONE  = (WR_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    typedef enum logic {
        GNT_WRITE,
        GNT_READ
    } grant_t;

    state_t                r_state;
    grant_t                r_last_grant;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_ack;
    logic                  r_rd_ack;
    logic                  r_rd_err;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_mem_wr_en;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
    logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;

    logic                  w_grant_wr;
    logic                  w_grant_rd;

    // A read's ack is shown during the first IDLE cycle while the reader still
    // holds rd_req, so no grant is allowed in that cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (r_state == ST_IDLE && !r_rd_ack) begin
            if (wr_req && rd_req) begin
`ifdef FB_ARB_WR_PRIORITY_EN
                w_grant_wr = 1'b1;
`else
                w_grant_wr = (r_last_grant == GNT_READ);
                w_grant_rd = (r_last_grant == GNT_WRITE);
`endif
            end else begin
                w_grant_wr = wr_req;
                w_grant_rd = rd_req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GNT_READ;
            r_cnt         <= '0;
            r_wr_ack      <= 1'b0;
            r_rd_ack      <= 1'b0;
            r_rd_err      <= 1'b0;
            r_rd_data     <= '0;
            r_mem_wr_en   <= 1'b1;
            r_mem_rd_en   <= 1'b1;
            r_mem_wr_addr <= '0;
            r_mem_rd_addr <= '0;
            r_mem_wr_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            case (r_state)
                ST_IDLE: begin
                    r_wr_ack <= 1'b0;
                    r_rd_ack <= 1'b0;
                    r_rd_err <= 1'b0;
                    if (w_grant_wr) begin
                        r_state       <= ST_WRITE;
                        r_last_grant  <= GNT_WRITE;
                        r_mem_wr_en   <= 1'b0;
                        r_mem_wr_addr <= wr_req_addr;
                        r_mem_wr_data <= wr_req_data;
                        r_cnt         <= WR_LOAD;
                        r_wr_ack      <= WR_ONE;
                    end else if (w_grant_rd) begin
                        r_state       <= ST_READ;
                        r_last_grant  <= GNT_READ;
                        r_mem_rd_en   <= 1'b0;
                        r_mem_rd_addr <= rd_req_addr;
                        r_cnt         <= '0;
                    end
                end

                // r_cnt counts the strobe cycles still to go; ack rides on the last one.
                ST_WRITE: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_IDLE;
                        r_mem_wr_en <= 1'b1;
                        r_wr_ack    <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_wr_ack <= (r_cnt == CNT_W'(1));
                    end
                end

                // Valid is checked before the timeout so a coincident valid still wins.
                ST_READ: begin
                    if (mem_rd_data_valid) begin
                        r_state     <= ST_IDLE;
                        r_mem_rd_en <= 1'b1;
                        r_rd_data   <= mem_rd_data;
                        r_rd_ack    <= 1'b1;
                        r_rd_err    <= 1'b0;
                    end else if (r_cnt == RD_LAST) begin
                        r_state     <= ST_IDLE;
                        r_mem_rd_en <= 1'b1;
                        r_rd_ack    <= 1'b1;
                        r_rd_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_wr_en <= 1'b1;
                    r_mem_rd_en <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ack      = r_wr_ack;
    assign rd_ack      = r_rd_ack;
    assign rd_err      = r_rd_err;
    assign rd_data     = r_rd_data;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_rd_addr = r_mem_rd_addr;
    assign mem_wr_data = r_mem_wr_data;

`ifndef SYNTHESIS
    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
        (r_mem_wr_en || r_mem_rd_en));
`endif

endmodule

`default_nettype wire
